// File: rtl/rr_arbiter8x3_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
interface rr_arbiter8x3_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       expired;

  // Requester side: drives requests, observes the grant.
  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  grant_valid,
    input  expired
  );

  // Arbiter side: samples requests, drives the grant.
  modport slave (
    input  req,
    output grant,
    output grant_id,
    output grant_valid,
    output expired
  );
endinterface

// File: rtl/rr_arbiter8x3.sv
// Round-robin arbiter for eight requesters with a per-owner hold timeout.
// Emits a one-hot grant plus the encoded owner index; all outputs registered.
module rr_arbiter8x3 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter8x3_if.slave  bus
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned HOLD_W = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]        state,    state_nxt;
  logic [ID_W-1:0]   ptr,      ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [N_REQ-1:0]  grant_q,  grant_nxt;
  logic [ID_W-1:0]   gid_q,    gid_nxt;
  logic              gv_q,     gv_nxt;
  logic              exp_q,    exp_nxt;

  logic [ID_W-1:0]   after_owner;
  logic [ID_W:0]     win_ptr;
  logic [ID_W:0]     win_after;

  // First set bit scanning start, start+1, ... (mod 8); returns {found, index}.
  function automatic logic [ID_W:0] find_winner(input logic [N_REQ-1:0] v,
                                                input logic [ID_W-1:0]  start);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + ID_W'(i);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Pointer the owner hands over to, and the winners from both candidate pointers.
  always_comb begin
    after_owner = gid_q + ID_W'(1);
    win_ptr     = find_winner(bus.req, ptr);
    win_after   = find_winner(bus.req, after_owner);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    grant_nxt = grant_q;
    gid_nxt   = gid_q;
    gv_nxt    = gv_q;
    exp_nxt   = 1'b0;

    case (state)
      IDLE: begin
        hold_nxt  = '0;
        grant_nxt = '0;
        gid_nxt   = '0;
        gv_nxt    = 1'b0;
        if (win_ptr[ID_W]) begin
          state_nxt = GRANT;
          gid_nxt   = win_ptr[ID_W-1:0];
          grant_nxt = N_REQ'(1) << win_ptr[ID_W-1:0];
          gv_nxt    = 1'b1;
          hold_nxt  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!bus.req[gid_q] || hold_cnt >= HOLD_W'(MAX_HOLD)) begin
          // Release or timeout: owner moves to lowest priority.
          ptr_nxt = after_owner;
          exp_nxt = bus.req[gid_q];
          if (win_after[ID_W]) begin
            gid_nxt   = win_after[ID_W-1:0];
            grant_nxt = N_REQ'(1) << win_after[ID_W-1:0];
            gv_nxt    = 1'b1;
            hold_nxt  = HOLD_W'(1);
          end else begin
            state_nxt = IDLE;
            gid_nxt   = '0;
            grant_nxt = '0;
            gv_nxt    = 1'b0;
            hold_nxt  = '0;
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      gid_q    <= '0;
      gv_q     <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      grant_q  <= grant_nxt;
      gid_q    <= gid_nxt;
      gv_q     <= gv_nxt;
      exp_q    <= exp_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = gid_q;
  assign bus.grant_valid = gv_q;
  assign bus.expired     = exp_q;

endmodule

// File: tb/tb_rr_arbiter8x3.sv
// Directed bench for rr_arbiter8x3: a cycle model feeds an expected-result queue
// that is popped after every edge, plus explicit checks of the scenario outcomes.
module tb_rr_arbiter8x3;

  localparam int MH = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rr_arbiter8x3_if bus ();

  rr_arbiter8x3 #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: {grant, grant_id, grant_valid, expired} is 13 bits.
  int m_ptr, m_gid, m_hold;
  bit m_gv, m_exp;
  logic [12:0] sb_q[$];

  function automatic int pick(input logic [7:0] v, input int p);
    for (int i = 0; i < 8; i++)
      if (v[(p + i) % 8]) return (p + i) % 8;
    return -1;
  endfunction

  task automatic model_edge(input logic [7:0] r, input logic rs);
    int w;
    m_exp = 1'b0;
    if (rs) begin
      m_ptr = 0; m_gid = 0; m_hold = 0; m_gv = 1'b0;
    end else if (!m_gv) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_gid = w; m_gv = 1'b1; m_hold = 1; end
    end else if (!r[m_gid] || m_hold == MH) begin
      m_exp = r[m_gid];
      m_ptr = (m_gid + 1) % 8;
      w = pick(r, m_ptr);
      if (w >= 0) begin m_gid = w; m_hold = 1; end
      else begin m_gid = 0; m_gv = 1'b0; m_hold = 0; end
    end else begin
      m_hold = m_hold + 1;
    end
  endtask

  // Drive one cycle, queue the model's prediction, compare after the edge.
  task automatic step(input logic [7:0] r, input logic rs);
    logic [12:0] exp_v, obs_v;
    logic [7:0]  g;
    rst     = rs;
    bus.req = r;
    model_edge(r, rs);
    g = m_gv ? (8'd1 << m_gid) : 8'd0;
    sb_q.push_back({g, 3'(m_gid), m_gv, m_exp});
    @(posedge clk);
    #1;
    obs_v = {bus.grant, bus.grant_id, bus.grant_valid, bus.expired};
    exp_v = sb_q.pop_front();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL scoreboard: observed %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    bus.req = 8'h00;
    m_ptr = 0; m_gid = 0; m_hold = 0; m_gv = 1'b0; m_exp = 1'b0;

    // 1: reset with all requests high, then first grant goes to 0.
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    chk("t1_rst_grant", int'(bus.grant), 0);
    chk("t1_rst_gv", int'(bus.grant_valid), 0);
    chk("t1_rst_id", int'(bus.grant_id), 0);
    chk("t1_rst_exp", int'(bus.expired), 0);
    step(8'hFF, 1'b0);
    chk("t1_first_id", int'(bus.grant_id), 0);
    chk("t1_first_gv", int'(bus.grant_valid), 1);

    // 2: back-to-back handover 0 -> 7, then pointer wraps to 0.
    step(8'h00, 1'b1);
    step(8'h81, 1'b0);
    chk("t2_id0", int'(bus.grant_id), 0);
    step(8'h80, 1'b0);
    chk("t2_id7", int'(bus.grant_id), 7);
    chk("t2_gv7", int'(bus.grant_valid), 1);
    step(8'h00, 1'b0);
    chk("t2_idle", int'(bus.grant_valid), 0);
    step(8'hFF, 1'b0);
    chk("t2_wrap", int'(bus.grant_id), 0);

    // 3: all requesting, each owner held exactly MH cycles.
    step(8'h00, 1'b1);
    for (int k = 0; k < 8 * MH + 4; k++) begin
      step(8'hFF, 1'b0);
      chk("t3_id", int'(bus.grant_id), (k / MH) % 8);
      chk("t3_exp", int'(bus.expired), (k > 0 && k % MH == 0) ? 1 : 0);
      chk("t3_onehot", int'(bus.grant), 1 << ((k / MH) % 8));
    end

    // 4: lone requester re-granted on every timeout.
    step(8'h00, 1'b1);
    for (int k = 0; k < 3 * MH; k++) begin
      step(8'h20, 1'b0);
      chk("t4_gv", int'(bus.grant_valid), 1);
      chk("t4_id", int'(bus.grant_id), 5);
      chk("t4_exp", int'(bus.expired), (k > 0 && k % MH == 0) ? 1 : 0);
    end

    // 5: late requests wait; priority continues after the owner.
    step(8'h00, 1'b1);
    step(8'h04, 1'b0);
    chk("t5_id2", int'(bus.grant_id), 2);
    step(8'h46, 1'b0);
    chk("t5_hold2", int'(bus.grant_id), 2);
    step(8'h42, 1'b0);
    chk("t5_id6", int'(bus.grant_id), 6);
    step(8'h02, 1'b0);
    chk("t5_id1", int'(bus.grant_id), 1);

    // 6: reset mid-grant, then restart with a fresh hold count.
    step(8'h00, 1'b1);
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    step(8'h08, 1'b1);
    chk("t6_rst_gv", int'(bus.grant_valid), 0);
    chk("t6_rst_grant", int'(bus.grant), 0);
    step(8'h08, 1'b0);
    chk("t6_id3", int'(bus.grant_id), 3);
    for (int k = 1; k <= MH; k++) begin
      step(8'h08, 1'b0);
      chk("t6_exp", int'(bus.expired), (k == MH) ? 1 : 0);
      chk("t6_id", int'(bus.grant_id), 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8x3.md
# rr_arbiter8x3

Round-robin arbiter sharing one resource among eight requesters, built around the 8-to-3 priority-encoding function. It holds a rotating priority pointer, grants one requester at a time, and keeps the grant until the owner releases or a hold timer expires. It emits both a one-hot grant vector and the encoded 3-bit owner index for downstream mux select.

## Interface
- MAX_HOLD, 4, maximum consecutive cycles one owner may hold the grant; legal range 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high means requester i wants or holds the resource.
- grant  output  8  one-hot grant; equals 1<<grant_id when grant_valid, else 0.
- grant_id  output  3  encoded index of the current owner.
- grant_valid  output  1  high while a grant is active.
- expired  output  1  one-cycle pulse on the edge where an owner loses grant due to hold timeout.

## Operation
- State: two-state FSM (IDLE, GRANT), 3-bit pointer ptr, 4-bit hold_cnt. All outputs registered.
- Winner search: first set bit of the candidate vector scanning ptr, ptr+1, … ptr+7 (mod 8). Exactly one winner, or none if the vector is zero.
- IDLE: grant=0, grant_valid=0, hold_cnt=0. If req != 0, then at the edge: grant the winner searched from ptr, set hold_cnt=1, go to GRANT. Else stay in IDLE.
- GRANT, continue: req[grant_id]=1 and hold_cnt<MAX_HOLD. Then hold_cnt increments and the outputs are unchanged.
- GRANT, release by owner: req[grant_id]=0. Set ptr = grant_id+1 mod 8 (7 wraps to 0). Search req from the new ptr.
  - If a winner exists, grant it back-to-back with hold_cnt=1 and stay in GRANT.
  - Otherwise go to IDLE and clear the outputs.
- GRANT, timeout: req[grant_id]=1 and hold_cnt==MAX_HOLD.
  - expired=1 for one cycle. ptr = grant_id+1 mod 8. Search req, which includes the owner, from the new ptr, so the owner has the lowest priority.
  - If the owner is the only requester, it is re-granted: grant_valid stays high, grant_id is unchanged, hold_cnt=1.
- Request bits that rise or fall on non-owner lines during GRANT have no effect until the next release or timeout.
- Reset, including mid-GRANT: at the reset edge, state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_id=0, grant_valid=0, expired=0. req is ignored during that edge.

## Timing
- Arbitration latency: a request seen at edge n in IDLE produces a grant after edge n, i.e. visible in cycle n+1. Latency is one cycle.
- Handover: the owner drops req before edge n. The new owner is visible after edge n. There are zero idle cycles between owners.
- Maximum continuous ownership: MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts one cycle and expired fires on every cycle in which the owner still requests.
- expired is high only in the cycle following the timeout edge, and is 0 in every other cycle.
- grant, grant_id and grant_valid change only at clock edges and never glitch combinationally.
- Starvation bound: a continuously requesting line is granted within 7*MAX_HOLD+1 cycles.

## Test plan
1. Reset with req=8'hFF held → after the reset edge, grant=0, grant_valid=0, grant_id=0, expired=0. Deassert rst → the first grant is grant_id=0 (ptr=0).
2. From IDLE, ptr=0, req=8'b1000_0001 → grant_id=0. Drop req[0] → the next edge gives grant_id=7 with no gap. Drop req[7] → IDLE, and ptr is now 0 (wrap from 7).
3. MAX_HOLD=4, req=8'hFF held → grant_id sequence 0,1,2,…,7,0, each held exactly 4 cycles. expired pulses once at each handover.
4. MAX_HOLD=4, req=8'h20 held → grant_valid stays continuously high with grant_id=5. expired pulses every 4 cycles and grant never drops.
5. Owner 2 holding; raise req[1] and req[6] mid-grant, then owner drops req → next grant_id=6, not 1. After 6 releases → grant_id=1.
6. Assert rst during GRANT with hold_cnt=3 → outputs are zero at the next edge. Release rst with req=8'h08 → grant_id=3 one cycle later, and hold_cnt restarts at 1.
